// File: rtl/rv32i_alu_if.sv
// Decode-to-ALU bus for rv32i_alu. Every field travels together on one clock.
//
// Handshake: there is no valid/ready pair. An op is presented every cycle and
// accepted at the rising edge unless either `cancelled` is high (the op is a
// bubble and is dropped) or `stall` is high (the ALU is busy and ignores the op;
// upstream must hold it and present it again).
interface rv32i_alu_if;
  // decode -> ALU
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] offset;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic [4:0]  a_rs_idx;
  logic [4:0]  b_rs_idx;
  logic        branch;
  logic        jump;
  logic        jal;
  logic        system;
  logic        load;
  logic        store;
  logic [2:0]  ld_st_width;
  logic        arith;
  logic        add_nsub;
  logic        cmp_unsigned;
  logic        cmp_is_lt;
  logic        cmp_is_ge;
  logic        cmp_is_eq;
  logic        cmp_is_ne;
  logic        bit_is_and;
  logic        bit_is_or;
  logic        bit_is_xor;
  logic        shift_arith;
  logic        shift_left;
  logic        shift_right;
  logic        cancelled;
  // ALU -> writeback / memory / fetch
  logic [4:0]  rd_out;
  logic [31:0] rd_val;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [2:0]  width_out;
  logic        load_out;
  logic        store_out;
  logic        update_pc;
  logic [31:0] new_pc;
  logic        stall;

  modport master (
    output a, b, offset, pc, rd, a_rs_idx, b_rs_idx,
    output branch, jump, jal, system, load, store, ld_st_width,
    output arith, add_nsub, cmp_unsigned, cmp_is_lt, cmp_is_ge, cmp_is_eq, cmp_is_ne,
    output bit_is_and, bit_is_or, bit_is_xor, shift_arith, shift_left, shift_right, cancelled,
    input  rd_out, rd_val, addr, store_data, width_out, load_out, store_out,
    input  update_pc, new_pc, stall
  );

  modport slave (
    input  a, b, offset, pc, rd, a_rs_idx, b_rs_idx,
    input  branch, jump, jal, system, load, store, ld_st_width,
    input  arith, add_nsub, cmp_unsigned, cmp_is_lt, cmp_is_ge, cmp_is_eq, cmp_is_ne,
    input  bit_is_and, bit_is_or, bit_is_xor, shift_arith, shift_left, shift_right, cancelled,
    output rd_out, rd_val, addr, store_data, width_out, load_out, store_out,
    output update_pc, new_pc, stall
  );
endinterface

// File: rtl/rv32i_alu.sv
// rv32i_alu: single-stage RV32I execute unit with writeback forwarding.
// Optional macro RV32_ALU_SERIAL_SHIFT_EN replaces the barrel shifter with a
// 1-bit-per-cycle shifter (IDLE->SHIFT->IDLE) that holds upstream via stall.
// o_dbg_state exposes the shifter FSM (1 = SHIFT); it is 0 in the barrel build.
module rv32i_alu #(
  parameter int RV32_ZICSR_EN = 1
) (
  input  logic      clk,
  input  logic      reset,
  rv32i_alu_if.slave bus,
  output logic      o_dbg_state
);

  localparam logic LP_ZICSR = (RV32_ZICSR_EN != 0);

  logic [4:0]  r_rd_out;
  logic [31:0] r_rd_val;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic [2:0]  r_width_out;
  logic        r_load_out;
  logic        r_store_out;
  logic        r_update_pc;
  logic [31:0] r_new_pc;

  logic        w_fwd_a;
  logic        w_fwd_b;
  logic [31:0] w_a_eff;
  logic [31:0] w_b_eff;
  logic        w_system;
  logic        w_lt;
  logic        w_eq;
  logic        w_taken;
  logic [4:0]  w_shamt;
  logic [31:0] w_mem_addr;

  logic [4:0]  w_op_rd_out;
  logic [31:0] w_op_rd_val;
  logic        w_op_update_pc;
  logic [31:0] w_op_new_pc;
  logic        w_op_is_shift;

  // A load's rd_val is its address, not the loaded data, so it must never be forwarded.
  assign w_fwd_a  = (bus.a_rs_idx != 5'd0) && (bus.a_rs_idx == r_rd_out) && !r_load_out;
  assign w_fwd_b  = (bus.b_rs_idx != 5'd0) && (bus.b_rs_idx == r_rd_out) && !r_load_out;
  assign w_a_eff  = w_fwd_a ? r_rd_val : bus.a;
  assign w_b_eff  = w_fwd_b ? r_rd_val : bus.b;
  assign w_system = bus.system & LP_ZICSR;

  assign w_lt       = bus.cmp_unsigned ? (w_a_eff < w_b_eff) : ($signed(w_a_eff) < $signed(w_b_eff));
  assign w_eq       = (w_a_eff == w_b_eff);
  assign w_taken    = (bus.cmp_is_eq & w_eq) | (bus.cmp_is_ne & ~w_eq) |
                      (bus.cmp_is_lt & w_lt) | (bus.cmp_is_ge & ~w_lt);
  assign w_shamt    = w_b_eff[4:0];
  assign w_mem_addr = w_a_eff + bus.offset;

`ifdef RV32_ALU_SERIAL_SHIFT_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} shift_state_t;

  shift_state_t r_state;
  shift_state_t w_state_nxt;
  logic [4:0]   r_count;
  logic [31:0]  r_sh_val;
  logic [4:0]   r_sh_rd;
  logic         r_sh_left;
  logic         r_sh_arith;
  logic [31:0]  w_sh_step;
  logic         w_start_shift;

  assign w_sh_step     = r_sh_left ? {r_sh_val[30:0], 1'b0}
                                   : {(r_sh_arith & r_sh_val[31]), r_sh_val[31:1]};
  assign w_start_shift = w_op_is_shift && (w_shamt != 5'd0) && !bus.cancelled;
  assign bus.stall     = (r_state == ST_SHIFT);
  assign o_dbg_state   = (r_state == ST_SHIFT);

  // Shifter FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shifter FSM next state: enter on a non-zero shift, leave on the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_shift) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_count == 5'd1) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end
`else
  assign bus.stall   = 1'b0;
  assign o_dbg_state = 1'b0;
`endif

  // Operation decode: writeback index/value and redirect for the presented op.
  always_comb begin
    w_op_rd_out    = bus.rd;
    w_op_rd_val    = 32'd0;
    w_op_update_pc = 1'b0;
    w_op_new_pc    = r_new_pc;
    w_op_is_shift  = 1'b0;
    if (bus.branch) begin
      w_op_rd_out = 5'd0;
      if (w_taken) begin
        w_op_update_pc = 1'b1;
        w_op_new_pc    = bus.pc + bus.offset;
      end
    end else if (bus.jump) begin
      w_op_rd_val    = bus.pc + 32'd4;
      w_op_update_pc = 1'b1;
      w_op_new_pc    = bus.jal ? (bus.pc + bus.offset) : ((w_a_eff + bus.offset) & ~32'd1);
    end else if (w_system) begin
      w_op_rd_out    = 5'd0;
      w_op_update_pc = 1'b1;
      w_op_new_pc    = bus.b;
    end else if (bus.load) begin
      w_op_rd_val = w_mem_addr;
    end else if (bus.store) begin
      w_op_rd_out = 5'd0;
    end else if (bus.arith) begin
      w_op_rd_val = bus.add_nsub ? (w_a_eff + w_b_eff) : (w_a_eff - w_b_eff);
    end else if (bus.cmp_is_lt) begin
      w_op_rd_val = {31'd0, w_lt};
    end else if (bus.bit_is_and) begin
      w_op_rd_val = w_a_eff & w_b_eff;
    end else if (bus.bit_is_or) begin
      w_op_rd_val = w_a_eff | w_b_eff;
    end else if (bus.bit_is_xor) begin
      w_op_rd_val = w_a_eff ^ w_b_eff;
    end else if (bus.shift_left || bus.shift_right) begin
      w_op_is_shift = 1'b1;
`ifdef RV32_ALU_SERIAL_SHIFT_EN
      // Only the shamt==0 case completes here; it is the operand unchanged.
      w_op_rd_val = w_a_eff;
`else
      if (bus.shift_left)       w_op_rd_val = w_a_eff << w_shamt;
      else if (bus.shift_arith) w_op_rd_val = $signed(w_a_eff) >>> w_shamt;
      else                      w_op_rd_val = w_a_eff >> w_shamt;
`endif
    end
  end

  // Result registers: reset, serial shift progress, bubble, or normal issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_out     <= 5'd0;
      r_rd_val     <= 32'd0;
      r_addr       <= 32'd0;
      r_store_data <= 32'd0;
      r_width_out  <= 3'd0;
      r_load_out   <= 1'b0;
      r_store_out  <= 1'b0;
      r_update_pc  <= 1'b0;
      r_new_pc     <= 32'd0;
`ifdef RV32_ALU_SERIAL_SHIFT_EN
      r_count      <= 5'd0;
      r_sh_val     <= 32'd0;
      r_sh_rd      <= 5'd0;
      r_sh_left    <= 1'b0;
      r_sh_arith   <= 1'b0;
`endif
    end
`ifdef RV32_ALU_SERIAL_SHIFT_EN
    else if (r_state == ST_SHIFT) begin
      r_sh_val <= w_sh_step;
      r_count  <= r_count - 5'd1;
      if (r_count == 5'd1) begin
        r_rd_out <= r_sh_rd;
        r_rd_val <= w_sh_step;
      end
    end
`endif
    else if (bus.cancelled) begin
      r_rd_out    <= 5'd0;
      r_load_out  <= 1'b0;
      r_store_out <= 1'b0;
      r_update_pc <= 1'b0;
    end else begin
      r_rd_out     <= w_op_rd_out;
      r_rd_val     <= w_op_rd_val;
      r_addr       <= w_mem_addr;
      r_store_data <= w_b_eff;
      r_width_out  <= bus.ld_st_width;
      r_load_out   <= bus.load;
      r_store_out  <= bus.store;
      r_update_pc  <= w_op_update_pc;
      r_new_pc     <= w_op_new_pc;
`ifdef RV32_ALU_SERIAL_SHIFT_EN
      if (w_start_shift) begin
        r_rd_out    <= 5'd0;
        r_load_out  <= 1'b0;
        r_store_out <= 1'b0;
        r_update_pc <= 1'b0;
        r_count     <= w_shamt;
        r_sh_val    <= w_a_eff;
        r_sh_rd     <= bus.rd;
        r_sh_left   <= bus.shift_left;
        r_sh_arith  <= bus.shift_arith;
      end
`endif
    end
  end

  assign bus.rd_out     = r_rd_out;
  assign bus.rd_val     = r_rd_val;
  assign bus.addr       = r_addr;
  assign bus.store_data = r_store_data;
  assign bus.width_out  = r_width_out;
  assign bus.load_out   = r_load_out;
  assign bus.store_out  = r_store_out;
  assign bus.update_pc  = r_update_pc;
  assign bus.new_pc     = r_new_pc;

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed bench for rv32i_alu; serial-shift vectors are used when
// RV32_ALU_SERIAL_SHIFT_EN is defined, barrel-shift vectors otherwise.
module tb_rv32i_alu;

  logic clk;
  logic reset;
  logic dbg_state;
  int   checks;
  int   errors;

  rv32i_alu_if alu_bus ();

  rv32i_alu #(.RV32_ZICSR_EN(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (alu_bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_bus.a = '0; alu_bus.b = '0; alu_bus.offset = '0; alu_bus.pc = '0;
    alu_bus.rd = '0; alu_bus.a_rs_idx = '0; alu_bus.b_rs_idx = '0;
    alu_bus.branch = 0; alu_bus.jump = 0; alu_bus.jal = 0; alu_bus.system = 0;
    alu_bus.load = 0; alu_bus.store = 0; alu_bus.ld_st_width = '0;
    alu_bus.arith = 0; alu_bus.add_nsub = 0; alu_bus.cmp_unsigned = 0;
    alu_bus.cmp_is_lt = 0; alu_bus.cmp_is_ge = 0; alu_bus.cmp_is_eq = 0; alu_bus.cmp_is_ne = 0;
    alu_bus.bit_is_and = 0; alu_bus.bit_is_or = 0; alu_bus.bit_is_xor = 0;
    alu_bus.shift_arith = 0; alu_bus.shift_left = 0; alu_bus.shift_right = 0;
    alu_bus.cancelled = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // directed sequence with hand-computed expectations
  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    check("rst_rd_out", 32'(alu_bus.rd_out), 32'd0);
    check("rst_rd_val", alu_bus.rd_val, 32'd0);
    check("rst_addr", alu_bus.addr, 32'd0);
    check("rst_update_pc", 32'(alu_bus.update_pc), 32'd0);
    check("rst_new_pc", alu_bus.new_pc, 32'd0);
    check("rst_stall", 32'(alu_bus.stall), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // SUB 5-7 -> x3
    clear_inputs();
    alu_bus.a = 32'd5; alu_bus.b = 32'd7; alu_bus.arith = 1; alu_bus.rd = 5'd3;
    tick();
    check("sub_rd_out", 32'(alu_bus.rd_out), 32'd3);
    check("sub_rd_val", alu_bus.rd_val, 32'hFFFF_FFFE);

    // ADD 4+6 -> x4, then forward x4 into a
    clear_inputs();
    alu_bus.a = 32'd4; alu_bus.b = 32'd6; alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd4;
    tick();
    check("add_rd_val", alu_bus.rd_val, 32'd10);
    clear_inputs();
    alu_bus.a_rs_idx = 5'd4; alu_bus.a = 32'd0; alu_bus.b = 32'd1;
    alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd5;
    tick();
    check("fwd_a_rd_val", alu_bus.rd_val, 32'd11);

    // forward x5 into b: 20 - 11
    clear_inputs();
    alu_bus.a = 32'd20; alu_bus.b_rs_idx = 5'd5; alu_bus.b = 32'd0; alu_bus.arith = 1; alu_bus.rd = 5'd6;
    tick();
    check("fwd_b_rd_val", alu_bus.rd_val, 32'd9);

    // load to x4, then no forwarding
    clear_inputs();
    alu_bus.load = 1; alu_bus.a = 32'h100; alu_bus.offset = 32'h10; alu_bus.rd = 5'd4; alu_bus.ld_st_width = 3'd2;
    tick();
    check("ld_rd_out", 32'(alu_bus.rd_out), 32'd4);
    check("ld_rd_val", alu_bus.rd_val, 32'h110);
    check("ld_addr", alu_bus.addr, 32'h110);
    check("ld_load_out", 32'(alu_bus.load_out), 32'd1);
    check("ld_width", 32'(alu_bus.width_out), 32'd2);
    clear_inputs();
    alu_bus.a_rs_idx = 5'd4; alu_bus.a = 32'd0; alu_bus.b = 32'd1;
    alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd7;
    tick();
    check("nofwd_ld_rd_val", alu_bus.rd_val, 32'd1);
    check("nofwd_ld_load_out", 32'(alu_bus.load_out), 32'd0);

    // compares
    clear_inputs();
    alu_bus.cmp_is_lt = 1; alu_bus.a = 32'hFFFF_FFFF; alu_bus.b = 32'd1; alu_bus.rd = 5'd8;
    tick();
    check("slt_rd_val", alu_bus.rd_val, 32'd1);
    clear_inputs();
    alu_bus.cmp_is_lt = 1; alu_bus.cmp_unsigned = 1; alu_bus.a = 32'hFFFF_FFFF; alu_bus.b = 32'd1; alu_bus.rd = 5'd8;
    tick();
    check("sltu_rd_val", alu_bus.rd_val, 32'd0);

    // bitwise
    clear_inputs();
    alu_bus.a = 32'hF0F0_00FF; alu_bus.b = 32'h0FF0_0F0F; alu_bus.bit_is_and = 1; alu_bus.rd = 5'd9;
    tick();
    check("and_rd_val", alu_bus.rd_val, 32'h00F0_000F);
    alu_bus.bit_is_and = 0; alu_bus.bit_is_or = 1;
    tick();
    check("or_rd_val", alu_bus.rd_val, 32'hFFF0_0FFF);
    alu_bus.bit_is_or = 0; alu_bus.bit_is_xor = 1;
    tick();
    check("xor_rd_val", alu_bus.rd_val, 32'hFF00_0FF0);

    // taken branch, then pulse drops
    clear_inputs();
    alu_bus.branch = 1; alu_bus.cmp_is_lt = 1; alu_bus.a = 32'hFFFF_FFFF; alu_bus.b = 32'd1;
    alu_bus.pc = 32'h100; alu_bus.offset = 32'h20; alu_bus.rd = 5'd9;
    tick();
    check("br_update_pc", 32'(alu_bus.update_pc), 32'd1);
    check("br_new_pc", alu_bus.new_pc, 32'h120);
    check("br_rd_out", 32'(alu_bus.rd_out), 32'd0);
    clear_inputs();
    tick();
    check("br_pulse_end", 32'(alu_bus.update_pc), 32'd0);

    // not-taken branch
    clear_inputs();
    alu_bus.branch = 1; alu_bus.cmp_is_eq = 1; alu_bus.a = 32'd1; alu_bus.b = 32'd2;
    alu_bus.pc = 32'h200; alu_bus.offset = 32'h40; alu_bus.rd = 5'd9;
    tick();
    check("bnt_update_pc", 32'(alu_bus.update_pc), 32'd0);
    check("bnt_rd_out", 32'(alu_bus.rd_out), 32'd0);

    // JALR and JAL
    clear_inputs();
    alu_bus.jump = 1; alu_bus.a = 32'h1001; alu_bus.offset = 32'd4; alu_bus.pc = 32'h80; alu_bus.rd = 5'd1;
    tick();
    check("jalr_new_pc", alu_bus.new_pc, 32'h1004);
    check("jalr_rd_val", alu_bus.rd_val, 32'h84);
    check("jalr_rd_out", 32'(alu_bus.rd_out), 32'd1);
    check("jalr_update_pc", 32'(alu_bus.update_pc), 32'd1);
    clear_inputs();
    alu_bus.jump = 1; alu_bus.jal = 1; alu_bus.a = 32'h5555; alu_bus.offset = 32'h40; alu_bus.pc = 32'h200; alu_bus.rd = 5'd1;
    tick();
    check("jal_new_pc", alu_bus.new_pc, 32'h240);

    // system
    clear_inputs();
    alu_bus.system = 1; alu_bus.b = 32'h300; alu_bus.rd = 5'd2;
    tick();
    check("sys_update_pc", 32'(alu_bus.update_pc), 32'd1);
    check("sys_new_pc", alu_bus.new_pc, 32'h300);
    check("sys_rd_out", 32'(alu_bus.rd_out), 32'd0);

    // store
    clear_inputs();
    alu_bus.store = 1; alu_bus.a = 32'h1000; alu_bus.offset = 32'd8; alu_bus.b = 32'hDEAD_BEEF;
    alu_bus.ld_st_width = 3'd1; alu_bus.rd = 5'd3;
    tick();
    check("st_addr", alu_bus.addr, 32'h1008);
    check("st_data", alu_bus.store_data, 32'hDEAD_BEEF);
    check("st_store_out", 32'(alu_bus.store_out), 32'd1);
    check("st_width", 32'(alu_bus.width_out), 32'd1);
    check("st_rd_out", 32'(alu_bus.rd_out), 32'd0);

    // cancelled op is a bubble and keeps rd_val
    clear_inputs();
    alu_bus.a = 32'd1; alu_bus.b = 32'd2; alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd5;
    tick();
    check("pre_cancel_rd_val", alu_bus.rd_val, 32'd3);
    clear_inputs();
    alu_bus.a = 32'd9; alu_bus.b = 32'd9; alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd6;
    alu_bus.cancelled = 1;
    tick();
    check("cancel_rd_out", 32'(alu_bus.rd_out), 32'd0);
    check("cancel_rd_val", alu_bus.rd_val, 32'd3);
    check("cancel_update_pc", 32'(alu_bus.update_pc), 32'd0);

`ifdef RV32_ALU_SERIAL_SHIFT_EN
    // serial SRA by 4: four stall cycles, an ADD offered meanwhile is ignored
    clear_inputs();
    alu_bus.shift_right = 1; alu_bus.shift_arith = 1; alu_bus.a = 32'h8000_0000; alu_bus.b = 32'd4; alu_bus.rd = 5'd10;
    tick();
    check("ssra_entry_rd_out", 32'(alu_bus.rd_out), 32'd0);
    check("ssra_stall_1", 32'(alu_bus.stall), 32'd1);
    clear_inputs();
    alu_bus.a = 32'd1; alu_bus.b = 32'd1; alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd11;
    tick();
    check("ssra_stall_2", 32'(alu_bus.stall), 32'd1);
    check("ssra_busy_rd_out", 32'(alu_bus.rd_out), 32'd0);
    tick();
    check("ssra_stall_3", 32'(alu_bus.stall), 32'd1);
    tick();
    check("ssra_stall_4", 32'(alu_bus.stall), 32'd1);
    clear_inputs();
    tick();
    check("ssra_done_stall", 32'(alu_bus.stall), 32'd0);
    check("ssra_rd_out", 32'(alu_bus.rd_out), 32'd10);
    check("ssra_rd_val", alu_bus.rd_val, 32'hF800_0000);

    // shamt 0 completes in one cycle without stall
    clear_inputs();
    alu_bus.shift_left = 1; alu_bus.a = 32'h1234_5678; alu_bus.b = 32'h20; alu_bus.rd = 5'd12;
    tick();
    check("ss0_stall", 32'(alu_bus.stall), 32'd0);
    check("ss0_rd_val", alu_bus.rd_val, 32'h1234_5678);

    // reset in the second SHIFT cycle abandons the shift
    clear_inputs();
    alu_bus.shift_left = 1; alu_bus.a = 32'd1; alu_bus.b = 32'd8; alu_bus.rd = 5'd13;
    tick();
    clear_inputs();
    tick();
    check("ssrst_busy", 32'(alu_bus.stall), 32'd1);
    reset = 1'b1;
    tick();
    check("ssrst_stall", 32'(alu_bus.stall), 32'd0);
    check("ssrst_rd_out", 32'(alu_bus.rd_out), 32'd0);
    reset = 1'b0;
    alu_bus.a = 32'd2; alu_bus.b = 32'd3; alu_bus.arith = 1; alu_bus.add_nsub = 1; alu_bus.rd = 5'd14;
    tick();
    check("ssrst_after_rd_out", 32'(alu_bus.rd_out), 32'd14);
    check("ssrst_after_rd_val", alu_bus.rd_val, 32'd5);
`else
    // barrel shifts, single cycle, no stall
    clear_inputs();
    alu_bus.shift_right = 1; alu_bus.shift_arith = 1; alu_bus.a = 32'h8000_0000; alu_bus.b = 32'd4; alu_bus.rd = 5'd10;
    tick();
    check("sra_rd_val", alu_bus.rd_val, 32'hF800_0000);
    check("sra_stall", 32'(alu_bus.stall), 32'd0);
    alu_bus.shift_arith = 0;
    tick();
    check("srl_rd_val", alu_bus.rd_val, 32'h0800_0000);
    clear_inputs();
    alu_bus.shift_left = 1; alu_bus.a = 32'd1; alu_bus.b = 32'd31; alu_bus.rd = 5'd10;
    tick();
    check("sll31_rd_val", alu_bus.rd_val, 32'h8000_0000);
    alu_bus.b = 32'h24;
    tick();
    check("sll_shamt_mask", alu_bus.rd_val, 32'h0000_0010);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
